// File: rtl/ifu_pq.sv
// ifu_pq: DEPTH-entry instruction prefetch queue between fetch stage and I-Port (IFU_PQ_BYPASS_EN adds empty-queue bypass)
module ifu_pq #(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    INSTR_SIZE = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          i_flush,
  input  logic [ADDR_WIDTH-1:0]         i_flush_addr,
  input  logic                          i_pop,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_instr,
  output logic [ADDR_WIDTH-1:0]         o_pc,
  output logic                          o_err_align,
  output logic                          o_err_bus,
  output logic [$clog2(DEPTH):0]        o_count,
  output logic [ADDR_WIDTH-1:0]         o_IAddr,
  output logic                          o_IRdC,
  input  logic [DATA_WIDTH-1:0]         i_IData,
  input  logic                          i_IRdy,
  input  logic                          i_IErr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + ADDR_WIDTH + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d, iaddr_q, iaddr_d, fpc_inc;
  logic                  irdc_q, irdc_d;
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         head_q, head_w;
  logic                  enq, pop, byp, resp, enq_ea, enq_eb;
  logic [DATA_WIDTH-1:0] enq_instr;
  logic [ADDR_WIDTH-1:0] enq_pc;

  assign resp    = i_IRdy | i_IErr;
  assign pop     = i_pop & (count_q != '0) & ~i_flush;
  assign fpc_inc = fpc_q + ADDR_WIDTH'(INSTR_SIZE);
`ifdef IFU_PQ_BYPASS_EN
  assign byp = (state_q == REQ) & i_IRdy & ~i_IErr & ~i_flush & (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  // State, fetch PC, bus command, pointers and held head copy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      fpc_q   <= RESET_ADDR;
      iaddr_q <= RESET_ADDR;
      irdc_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= {DATA_WIDTH'(0), RESET_ADDR, 2'b00};
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      iaddr_q <= iaddr_d;
      irdc_q  <= irdc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= o_valid ? head_w : head_q;
    end
  end

  // Queue storage; no reset needed since entries are only read when counted valid
  always_ff @(posedge clk) begin
    if (enq) mem[wptr_q] <= {enq_instr, enq_pc, enq_ea, enq_eb};
  end

  // Next state: request issue, response capture, drain and flush override
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    irdc_d    = irdc_q;
    iaddr_d   = iaddr_q;
    enq       = 1'b0;
    enq_instr = i_IData;
    enq_pc    = iaddr_q;
    enq_ea    = 1'b0;
    enq_eb    = 1'b0;
    case (state_q)
      IDLE: if (count_q < FULL) begin
        if (fpc_q[1:0] != 2'b00) begin
          enq       = 1'b1;
          enq_instr = '0;
          enq_pc    = fpc_q;
          enq_ea    = 1'b1;
          state_d   = HALT;
        end else begin
          state_d = REQ;
          irdc_d  = 1'b1;
          iaddr_d = fpc_q;
        end
      end
      REQ: if (i_IErr) begin
        enq       = 1'b1;
        enq_instr = '0;
        enq_eb    = 1'b1;
        irdc_d    = 1'b0;
        state_d   = HALT;
      end else if (i_IRdy) begin
        enq   = ~(byp & i_pop);
        fpc_d = fpc_inc;
        if ((count_q + CW'(enq) - CW'(pop)) < FULL && fpc_inc[1:0] == 2'b00) iaddr_d = fpc_inc;
        else begin
          irdc_d  = 1'b0;
          state_d = IDLE;
        end
      end
      DRAIN: if (resp) begin
        irdc_d  = 1'b0;
        state_d = IDLE;
      end
      default: ;
    endcase
    if (i_flush) begin
      enq   = 1'b0;
      fpc_d = i_flush_addr;
      if ((state_q == REQ || state_q == DRAIN) && !resp) begin
        state_d = DRAIN;
        irdc_d  = 1'b1;
        iaddr_d = iaddr_q;
      end else begin
        state_d = IDLE;
        irdc_d  = 1'b0;
      end
    end
    count_d = i_flush ? '0 : count_q + CW'(enq) - CW'(pop);
    wptr_d  = i_flush ? '0 : wptr_q + AW'(enq);
    rptr_d  = i_flush ? '0 : rptr_q + AW'(pop);
  end

  // Outputs: head entry, bypassed bus word, or the last shown head while empty
  always_comb begin
    head_w  = (count_q != '0) ? mem[rptr_q] : byp ? {i_IData, iaddr_q, 2'b00} : head_q;
    o_valid = (count_q != '0) | byp;
    {o_instr, o_pc, o_err_align, o_err_bus} = head_w;
    o_count = count_q;
    o_IAddr = iaddr_q;
    o_IRdC  = irdc_q;
  end
endmodule
